// File: rtl/m_mem_responder.sv
// Data-side memory responder for the single-cycle core: word RAM, free-running
// cycle counter and a FIFO-fed 8N1 serial transmitter behind a small address map.
//
// state   | meaning
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (low) for BAUD_DIV cycles
// S_DATA  | eight data bits, LSB first, BAUD_DIV cycles each
// S_STOP  | stop bit (high); chains straight into the next frame if the FIFO has data
module m_mem_responder #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int BAUD_DIV   = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_WE,
   input  logic [31:0] i_address,
   input  logic [31:0] i_data,
   output logic [31:0] o_data,
   output logic        o_tx,
   output logic        o_tx_busy
);

   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [29:0] W_CYCLE  = 30'h3FFF_C000;
   localparam logic [29:0] W_TXDATA = 30'h3FFF_C001;
   localparam logic [29:0] W_STATUS = 30'h3FFF_C002;

   logic [29:0]    word_addr;
   logic           ram_sel, cyc_sel, txd_sel, sts_sel;
   logic [AW-1:0]  ram_idx;
   logic           unused_addr_bits;

   logic [31:0]    ram [RAM_WORDS];
   logic [31:0]    cycle;

   logic [7:0]     fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [3:0]     count;
   logic           overflow, full, empty, push, push_ok, pop;
   logic [7:0]     head;

   logic [1:0]     state;
   logic [BW-1:0]  baud;
   logic [2:0]     bit_cnt;
   logic [7:0]     shift;
   logic           tick;
   logic [31:0]    status;

   assign word_addr        = i_address[31:2];
   assign unused_addr_bits = ^i_address[1:0];
   assign ram_sel          = (i_address[31:AW+2] == '0);
   assign ram_idx          = i_address[AW+1:2];
   assign cyc_sel          = (word_addr == W_CYCLE);
   assign txd_sel          = (word_addr == W_TXDATA);
   assign sts_sel          = (word_addr == W_STATUS);

   assign full    = (count == 4'(FIFO_DEPTH));
   assign empty   = (count == 4'd0);
   assign head    = fifo_mem[rd_ptr];
   assign push    = i_WE & txd_sel & ~i_reset;
   assign push_ok = push & ~full;
   assign tick    = (baud == '0);
   // The head leaves the FIFO when an idle line wakes up or a stop bit finishes.
   assign pop     = ~empty & ((state == S_IDLE) | ((state == S_STOP) & tick));

   assign o_tx_busy = (state != S_IDLE) | ~empty;
   assign status    = {24'b0, count, overflow, o_tx_busy, full, empty};

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      o_data = '0;
      if (ram_sel)      o_data = ram[ram_idx];
      else if (cyc_sel) o_data = cycle;
      else if (sts_sel) o_data = status;
   end

   // RAM writes are deliberately not blocked by reset.
   always_ff @(posedge i_clk) begin
      if (i_WE && ram_sel) ram[ram_idx] <= i_data;
      if (push_ok) fifo_mem[wr_ptr] <= i_data[7:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cycle    <= '0;
         overflow <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         cycle <= (i_WE && cyc_sel) ? i_data : cycle + 32'd1;
         if (i_WE && sts_sel)   overflow <= 1'b0;
         else if (push && full) overflow <= 1'b1;
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)     rd_ptr <= ptr_inc(rd_ptr);
         count <= count + {3'b0, push_ok} - {3'b0, pop};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         o_tx    <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  state <= S_START;
                  shift <= head;
                  baud  <= BAUD_LAST;
                  o_tx  <= 1'b0;
               end
            end
            S_START: begin
               if (tick) begin
                  state   <= S_DATA;
                  baud    <= BAUD_LAST;
                  bit_cnt <= '0;
                  o_tx    <= shift[0];
               end else begin
                  baud <= baud - BW'(1);
               end
            end
            S_DATA: begin
               if (tick) begin
                  baud <= BAUD_LAST;
                  if (bit_cnt == 3'd7) begin
                     state <= S_STOP;
                     o_tx  <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     o_tx    <= shift[1];
                  end
               end else begin
                  baud <= baud - BW'(1);
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (!empty) begin
                     state <= S_START;
                     shift <= head;
                     baud  <= BAUD_LAST;
                     o_tx  <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  baud <= baud - BW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_mem_responder.sv
// Bench for m_mem_responder: directed scenarios plus random traffic, all checked
// against a frame-level reference model of RAM, counter, FIFO and serial line.
module tb_m_mem_responder;

   localparam int RW    = 64;
   localparam int FD    = 4;
   localparam int BD    = 4;
   localparam int FRAME = 10 * BD;
   localparam logic [31:0] A_CYC = 32'hFFFF_0000;
   localparam logic [31:0] A_TX  = 32'hFFFF_0004;
   localparam logic [31:0] A_ST  = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        tx, busy;

   m_mem_responder #(.RAM_WORDS(RW), .FIFO_DEPTH(FD), .BAUD_DIV(BD)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_WE      (we),
      .i_address (addr),
      .i_data    (wdata),
      .o_data    (rdata),
      .o_tx      (tx),
      .o_tx_busy (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_ram [RW];
   bit          m_valid [RW];
   logic [31:0] m_cycle;
   logic [7:0]  m_q [$];
   bit          m_ovf;
   bit          m_active;
   int          m_pos;
   logic [7:0]  m_cur;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_busy();
      return m_active || (m_q.size() > 0);
   endfunction

   function automatic logic ref_tx();
      int b;
      if (!m_active) return 1'b1;
      b = m_pos / BD;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[b-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] ref_status();
      return {24'b0, 4'(m_q.size()), m_ovf, ref_busy(), (m_q.size() == FD), (m_q.size() == 0)};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, output bit known);
      logic [31:0] w;
      int idx;
      w = {a[31:2], 2'b00};
      known = 1'b1;
      if (w < 32'(RW * 4)) begin
         idx = int'(w[31:2]);
         known = m_valid[idx];
         return m_ram[idx];
      end
      if (w == A_CYC) return m_cycle;
      if (w == A_ST)  return ref_status();
      return 32'h0;
   endfunction

   task automatic model_edge(input bit w_en, input logic [31:0] a, input logic [31:0] d, input bit r);
      logic [31:0] w;
      bit frame_end, start, full_pre;
      int idx;
      w = {a[31:2], 2'b00};
      if (w_en && w < 32'(RW * 4)) begin
         idx = int'(w[31:2]);
         m_ram[idx] = d;
         m_valid[idx] = 1'b1;
      end
      if (r) begin
         m_cycle = '0;
         m_q.delete();
         m_ovf = 1'b0;
         m_active = 1'b0;
         m_pos = 0;
         return;
      end
      m_cycle   = (w_en && w == A_CYC) ? d : m_cycle + 32'd1;
      frame_end = m_active && (m_pos == FRAME - 1);
      start     = (!m_active || frame_end) && (m_q.size() > 0);
      full_pre  = (m_q.size() == FD);
      if (m_active) begin
         if (frame_end) m_active = 1'b0;
         else m_pos++;
      end
      if (w_en && w == A_TX) begin
         if (full_pre) m_ovf = 1'b1;
         else m_q.push_back(d[7:0]);
      end
      if (w_en && w == A_ST) m_ovf = 1'b0;
      if (start) begin
         m_cur = m_q.pop_front();
         m_active = 1'b1;
         m_pos = 0;
      end
   endtask

   // One cycle: drive on the falling edge, check outputs, then advance the model at the rising edge.
   task automatic step(input bit w_en, input logic [31:0] a, input logic [31:0] d, input bit r,
                       input bit lit_en, input logic [31:0] lit, input string tag);
      logic [31:0] exp;
      bit known;
      @(negedge clk);
      we = w_en; addr = a; wdata = d; rst = r;
      #1;
      exp = ref_read(a, known);
      if (known) check_val("rdata", rdata, exp);
      check_val("tx", {31'b0, tx}, {31'b0, ref_tx()});
      check_val("busy", {31'b0, busy}, {31'b0, ref_busy()});
      if (lit_en) check_val(tag, rdata, lit);
      @(posedge clk);
      model_edge(w_en, a, d, r);
   endtask

   task automatic idle();
      step(1'b0, A_ST, 32'h0, 1'b0, 1'b0, 32'h0, "");
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b1, a, d, 1'b0, 1'b0, 32'h0, "");
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] lit, input string tag);
      step(1'b0, a, 32'h0, 1'b0, 1'b1, lit, tag);
   endtask

   initial begin
      logic [7:0] b55;
      logic [31:0] a, d;
      int op, b;
      logic exp_bit;

      for (int i = 0; i < RW; i++) m_valid[i] = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_edge(1'b0, 32'h0, 32'h0, 1'b1);

      // reset state and counter
      rd(A_CYC, 32'h0, "rst_cycle");
      rd(A_ST, 32'h1, "rst_status");
      repeat (3) idle();
      rd(A_CYC, 32'd5, "cycle_after_release");
      wr(A_CYC, 32'hFFFF_FFFE);
      rd(A_CYC, 32'hFFFF_FFFE, "cycle_load");
      rd(A_CYC, 32'hFFFF_FFFF, "cycle_max");
      rd(A_CYC, 32'h0, "cycle_wrap");

      // RAM and unmapped
      wr(32'h14, 32'h1234_5678);
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
      rd(32'h13, 32'hDEAD_BEEF, "ram_rd_lowbits");
      rd(32'h14, 32'h1234_5678, "ram_neighbour");
      rd(32'(RW * 4), 32'h0, "unmapped_above_ram");
      rd(A_TX, 32'h0, "txdata_read");

      // single byte 0x55
      b55 = 8'h55;
      wr(A_TX, 32'h55);
      for (int j = 1; j <= FRAME; j++) begin
         idle();
         #1;
         b = (j - 1) / BD;
         exp_bit = (b == 0) ? 1'b0 : ((b <= 8) ? b55[b-1] : 1'b1);
         check_val("tx55_wave", {31'b0, tx}, {31'b0, exp_bit});
         check_val("tx55_busy", {31'b0, busy}, 32'h1);
      end
      idle();
      #1;
      check_val("tx55_busy_end", {31'b0, busy}, 32'h0);

      // back-to-back frames
      wr(A_TX, 32'h01);
      wr(A_TX, 32'h80);
      rd(A_ST, 32'h14, "b2b_count_after_pop");
      for (int k = 3; k <= 41; k++) begin
         idle();
         #1;
         if (k == 40) check_val("b2b_stop", {31'b0, tx}, 32'h1);
         if (k == 41) check_val("b2b_second_start", {31'b0, tx}, 32'h0);
      end
      repeat (45) idle();

      // overflow
      for (int i = 0; i < 6; i++) wr(A_TX, 32'(8'hA0 + i));
      rd(A_ST, 32'h4E, "ovf_status");
      wr(A_ST, 32'hFFFF_FFFF);
      rd(A_ST, 32'h46, "ovf_cleared");
      repeat (5 * FRAME + 10) idle();

      // reset mid-frame with a byte still queued
      wr(A_TX, 32'h3C);
      wr(A_TX, 32'hC3);
      repeat (14) idle();
      step(1'b0, A_ST, 32'h0, 1'b1, 1'b0, 32'h0, "");
      #1;
      check_val("rst_mid_tx", {31'b0, tx}, 32'h1);
      rd(A_ST, 32'h1, "rst_mid_status");
      for (int k = 0; k < 50; k++) begin
         idle();
         #1;
         check_val("rst_mid_quiet", {31'b0, tx}, 32'h1);
      end

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         op = $urandom_range(0, 99);
         a  = (32'($urandom_range(0, RW - 1)) << 2) | 32'($urandom_range(0, 3));
         d  = $urandom;
         if (op < 20)      wr(a, d);
         else if (op < 35) step(1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, "");
         else if (op < 50) wr(A_TX | 32'($urandom_range(0, 3)), d);
         else if (op < 60) idle();
         else if (op < 64) wr(A_ST, d);
         else if (op < 72) step(1'b0, A_CYC, 32'h0, 1'b0, 1'b0, 32'h0, "");
         else if (op < 75) wr(A_CYC, ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : d);
         else if (op < 80) begin
            case ($urandom_range(0, 2))
               0: a = 32'(RW * 4) + (d & 32'hFFC);
               1: a = 32'hFFFF_000C;
               default: a = 32'h8000_0000 | (d & 32'hFFFF);
            endcase
            step($urandom_range(0, 1) == 1, a, d, 1'b0, 1'b0, 32'h0, "");
         end else if (op < 82 && $urandom_range(0, 9) == 0) begin
            // reset edge carrying a write: RAM takes it, everything else ignores it
            case ($urandom_range(0, 2))
               0: step(1'b1, a, d, 1'b1, 1'b0, 32'h0, "");
               1: step(1'b1, A_TX, d, 1'b1, 1'b0, 32'h0, "");
               default: step(1'b1, A_CYC, d, 1'b1, 1'b0, 32'h0, "");
            endcase
         end else idle();
      end
      repeat (FRAME * (FD + 2)) idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/m_mem_responder.md
# m_mem_responder

Data-side memory responder for the single-cycle RISC-V core. It answers the core's `o_WE` / `o_address_to_mem` / `o_data_to_mem` / `i_data_from_mem` port with:
- a word-addressed data RAM;
- a free-running cycle counter;
- a FIFO-buffered 8N1 serial transmitter, so programs can emit bytes with plain `sw`.

Reads are combinational, so a `lw` completes in the same cycle. Writes and all peripheral state update on the clock edge.

## Interface
Parameters:
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4: TX byte FIFO depth; power of two, maximum 8.
- `BAUD_DIV`, 4: clock cycles per serial bit; at least 1.

Ports:
- `i_clk`, in, 1: clock. All state changes on the rising edge.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_WE`, in, 1: write enable from the core.
- `i_address`, in, 32: byte address from the core; bits [1:0] are ignored.
- `i_data`, in, 32: write data from the core.
- `o_data`, out, 32: read data to the core; combinational.
- `o_tx`, out, 1: serial line; registered; idles high.
- `o_tx_busy`, out, 1: high while a frame is in flight or the FIFO is non-empty.

## Operation
Address map (anything not listed is unmapped):
- `0x0000_0000` up to `RAM_WORDS*4-1`: RAM, indexed by `i_address[log2(RAM_WORDS)+1:2]`.
- `0xFFFF_0000` CYCLE:
  - Read returns the counter.
  - Write loads `i_data`.
- `0xFFFF_0004` TXDATA:
  - Write pushes `i_data[7:0]` into the FIFO.
  - Read returns 0.
- `0xFFFF_0008` STATUS:
  - Read returns `{24'b0, count[3:0], overflow, busy, full, empty}`.
  - Any write clears `overflow`.
- Unmapped addresses: reads return 0; writes are ignored.

Reset values:
- FIFO empty; `overflow` = 0; CYCLE = 0.
- TX state IDLE; `o_tx` = 1; `o_tx_busy` = 0.
- RAM contents are not initialised by reset.

Cycle counter:
- Increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
- A CYCLE write at an edge loads `i_data` at that edge. There is no increment at that edge.

FIFO:
- A push when full drops the byte and sets sticky `overflow`.
- A push on the same edge as a pop when full is still dropped.
- A push and pop on the same edge when not full: count is unchanged, and both operations take effect.

TX state machine (`baud` counter runs 0..`BAUD_DIV-1`, bit index 0..7):
- IDLE: `o_tx` = 1. If the FIFO is non-empty: pop the head into the shift register and go to START.
- START: `o_tx` = 0 for `BAUD_DIV` cycles, then go to DATA.
- DATA: `o_tx` = shift[0], LSB first. Shift after each `BAUD_DIV` cycles. After bit 7, go to STOP.
- STOP: `o_tx` = 1 for `BAUD_DIV` cycles. At its end:
  - FIFO non-empty: pop and go directly to START (no idle gap).
  - FIFO empty: go to IDLE.
- `busy` = (state != IDLE) or FIFO non-empty.

## Timing
- Read latency is 0: `o_data` follows `i_address` combinationally in the same cycle.
- RAM/CYCLE/STATUS writes take effect at the edge where `i_WE` = 1. A read at the same address in the following cycle returns the new value.
- TXDATA write into an empty FIFO with TX idle:
  - Edge N: push.
  - Edge N+1: pop; `o_tx` falls to 0.
- Frame length is exactly `10*BAUD_DIV` cycles. Back-to-back frames have no gap.
- STATUS reflects the state after the last edge. A push at edge N is visible in `count` from cycle N+1.
- Reset asserted mid-frame: at that edge `o_tx` returns to 1, the FIFO is flushed, and the partial frame is abandoned.
- `i_WE` is never gated by reset. Writes at an edge where `i_reset` = 1 are ignored for all targets except RAM, which still writes.

## Test plan
- RAM: sw `0xDEADBEEF` @`0x10`, then lw @`0x10` -> `0xDEADBEEF`. lw @`0x13` returns the same word. lw @`0x14` is unaffected.
- Counter:
  - 5 cycles after reset release, CYCLE reads 5.
  - Write `0xFFFF_FFFE`: reads `0xFFFF_FFFE`, then `0xFFFF_FFFF`, then `0`.
- Single byte, `BAUD_DIV`=4: write `0x55` to TXDATA.
  - `o_tx` goes low 1 edge after the push for 4 cycles.
  - Then 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles.
  - `busy` drops after exactly 40 cycles.
- Back-to-back: push `0x01`, `0x80` in consecutive cycles. Second start bit begins exactly 40 cycles after the first. STATUS `count` reads 1 after the first pop.
- Overflow, `FIFO_DEPTH`=4: 6 writes in consecutive cycles.
  - One byte is popped at the second edge.
  - 4 bytes buffered; the 6th is dropped.
  - STATUS = `0x4E`: count 4, overflow, busy, full.
  - A STATUS write clears bit 3 only.
- Reset mid-frame at cycle 15 of a frame: `o_tx` = 1 and STATUS = `0x01` from the next cycle. No further start bit.
